// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like port between the instruction-fetch and data masters.
//   clk, reset (async, active-high)
//   inst_* / data_* : master request side (req/wr/size/addr/wstrb/wdata in; addr_ok/data_ok/rdata out)
//   bus_*           : shared bus request out, bus_addr_ok/bus_data_ok/bus_rdata in
//   Define ARB_ROUND_ROBIN_EN to alternate grants on conflict; otherwise data beats inst.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  logic [PW:0]                count_q, count_d;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] order_q;
  logic                       lock_valid_q, lock_sel_q;
  logic                       pick, sel, full, hs, pop, head;
`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q;
  assign pick = (inst_req && data_req) ? ~rr_last_q : data_req;
`else
  assign pick = data_req;
`endif
  // sel: 0 = inst, 1 = data; a stalled request pins the mux until the bus takes it
  assign sel          = lock_valid_q ? lock_sel_q : pick;
  assign full         = count_q == (PW+1)'(MAX_OUTSTANDING);
  assign bus_req      = ~reset & ~full & (sel ? data_req : inst_req);
  assign hs           = bus_req & bus_addr_ok;
  // a response with nothing outstanding is dropped rather than misrouted
  assign pop          = ~reset & bus_data_ok & (count_q != '0);
  assign head         = order_q[rd_ptr_q];
  assign count_d      = count_q + (PW+1)'(hs) - (PW+1)'(pop);
  assign bus_wr       = sel ? data_wr    : inst_wr;
  assign bus_size     = sel ? data_size  : inst_size;
  assign bus_addr     = sel ? data_addr  : inst_addr;
  assign bus_wstrb    = sel ? data_wstrb : inst_wstrb;
  assign bus_wdata    = sel ? data_wdata : inst_wdata;
  assign inst_addr_ok = hs & ~sel;
  assign data_addr_ok = hs & sel;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      order_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_sel_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q    <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
      if (hs) begin
        order_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_q         <= sel;
`endif
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (bus_req && !bus_addr_ok) begin
        lock_valid_q <= 1'b1;
        lock_sel_q   <= sel;
      end else if (hs) begin
        lock_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: randomized scoreboard bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;
  localparam int MAXO = 4;
  logic        clk = 1'b0, reset = 1'b1;
  logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0]  inst_size = 0, data_size = 0, bus_size;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic [3:0]  inst_wstrb = 0, data_wstrb = 0, bus_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic        bus_req, bus_wr;
  logic        bus_addr_ok = 0, bus_data_ok = 0;
  logic [31:0] bus_rdata = 0;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit owner; logic [31:0] rdata; } resp_t;
  resp_t sb[$];
  resp_t mon_r;
  int n_cmp = 0, n_bad = 0;

  // reference model: queue of owners in acceptance order, pending flags per master
  bit mq[$];
  bit lock_m = 0, lock_sel_m = 0, rr_m = 0, ip = 0, dp = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(int p_new, int p_aok, int p_dok);
    bit own, breq, hs, pop;
    @(negedge clk);
    if (!ip && $urandom_range(99) < p_new) begin
      ip = 1;
      inst_addr  = $urandom & 32'hffff_fffc;
      inst_size  = 2'd2;
      inst_wr    = 0;
      inst_wstrb = 4'h0;
      inst_wdata = $urandom;
    end
    if (!dp && $urandom_range(99) < p_new) begin
      dp = 1;
      data_addr  = $urandom;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
    end
    inst_req    = ip;
    data_req    = dp;
    bus_addr_ok = $urandom_range(99) < p_aok;
    bus_data_ok = $urandom_range(99) < p_dok;
    bus_rdata   = $urandom;
`ifdef ARB_ROUND_ROBIN_EN
    own = lock_m ? lock_sel_m : (ip && dp) ? !rr_m : dp;
`else
    own = lock_m ? lock_sel_m : dp;
`endif
    breq = (mq.size() != MAXO) && (own ? dp : ip);
    hs   = breq && bus_addr_ok;
    pop  = bus_data_ok && mq.size() > 0;
    if (pop) sb.push_back('{mq[0], bus_rdata});
    #2;
    check("bus_req", 32'(bus_req), 32'(breq));
    check("inst_addr_ok", 32'(inst_addr_ok), 32'(hs && !own));
    check("data_addr_ok", 32'(data_addr_ok), 32'(hs && own));
    check("any_data_ok", 32'(inst_data_ok | data_data_ok), 32'(pop));
    if (breq) begin
      check("bus_addr", bus_addr, own ? data_addr : inst_addr);
      check("bus_wdata", bus_wdata, own ? data_wdata : inst_wdata);
      check("bus_ctl", {25'b0, bus_wr, bus_size, bus_wstrb},
            own ? {25'b0, data_wr, data_size, data_wstrb} : {25'b0, inst_wr, inst_size, inst_wstrb});
    end
    if (pop) void'(mq.pop_front());
    if (breq && !bus_addr_ok) begin
      lock_m = 1;
      lock_sel_m = own;
    end else if (hs) begin
      lock_m = 0;
    end
    if (hs) begin
      mq.push_back(own);
      rr_m = own;
      if (own) dp = 0; else ip = 0;
    end
  endtask

  task automatic reset_outputs_zero(string tag);
    check({tag, "_bus_req"}, 32'(bus_req), 0);
    check({tag, "_addr_ok"}, {30'b0, inst_addr_ok, data_addr_ok}, 0);
    check({tag, "_data_ok"}, {30'b0, inst_data_ok, data_data_ok}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    #1 reset = 1;
    #1 reset_outputs_zero("rst_async");
    @(posedge clk);
    #1 reset_outputs_zero("rst_hold");
    @(negedge clk);
    reset = 0;
    inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    mq.delete(); sb.delete();
    lock_m = 0; lock_sel_m = 0; rr_m = 0; ip = 0; dp = 0;
  endtask

  always @(negedge clk) begin
    #2;
    if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        check("resp_spurious", {30'b0, inst_data_ok, data_data_ok}, 0);
      end else begin
        mon_r = sb.pop_front();
        check("resp_owner", {30'b0, inst_data_ok, data_data_ok}, mon_r.owner ? 32'd1 : 32'd2);
        check("resp_rdata", mon_r.owner ? data_rdata : inst_rdata, mon_r.rdata);
      end
    end
  end

  initial begin
    do_reset();
    repeat (400) cycle(60, 70, 50);
    repeat (300) cycle(80, 80, 10);
    repeat (300) cycle(30, 40, 80);
    repeat (200) cycle(90, 90, 15);
    do_reset();
    repeat (5) cycle(0, 0, 100);
    repeat (400) cycle(60, 60, 50);
    repeat (60) cycle(0, 100, 100);
    @(negedge clk);
    #3;
    check("sb_drain", sb.size(), 0);
    check("model_drain", mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
